// File: rtl/verinject_ff_scheduler.sv
// Fault-injection scheduler: queues {cycle, target} pairs and drives the ff-injector
// state bus with each target for exactly one run cycle when the run counter reaches it.
module verinject_ff_scheduler #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] IDLE_STATE = 32'hFFFFFFFF
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [31:0] cfg_cycle,
    input  logic [31:0] cfg_target,
    input  logic        start,
    input  logic        abort,
    output logic [31:0] verinject__injector_state,
    output logic        busy,
    output logic        done,
    output logic        missed,
    output logic [7:0]  injected_count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q;
    logic [31:0]   cyc_mem_q [DEPTH];
    logic [31:0]   tgt_mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   fill_q;
    logic [31:0]   cnt_q;
    logic          missed_q;
    logic [7:0]    inj_cnt_q;

    logic          empty, full, hit, late, pop, push;
    logic [31:0]   head_cyc;
    logic [AW:0]   fill_rem;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign empty     = (fill_q == '0);
    assign full      = (fill_q == FULL_LVL);
    assign head_cyc  = cyc_mem_q[rd_ptr_q];
    // A late head (its cycle already passed) is dropped rather than injected.
    assign hit       = (state_q == S_RUN) && !empty && (head_cyc == cnt_q);
    assign late      = (state_q == S_RUN) && !empty && (head_cyc <  cnt_q);
    assign pop       = hit || late;
    assign fill_rem  = pop ? fill_q - 1'b1 : fill_q;
    assign cfg_ready = !full && (state_q != S_RUN);
    assign push      = reset_n && !abort && cfg_valid && cfg_ready;

    assign verinject__injector_state = hit ? tgt_mem_q[rd_ptr_q] : IDLE_STATE;
    assign busy           = (state_q == S_RUN);
    assign done           = (state_q == S_DONE);
    assign missed         = missed_q;
    assign injected_count = inj_cnt_q;

    always_ff @(posedge clock) begin
        if (push) begin
            cyc_mem_q[wr_ptr_q] <= cfg_cycle;
            tgt_mem_q[wr_ptr_q] <= cfg_target;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            missed_q  <= 1'b0;
            inj_cnt_q <= '0;
        end else if (abort) begin
            // An injection visible during the abort cycle has already reached the bus.
            state_q  <= S_IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            if (hit) inj_cnt_q <= sat_inc8(inj_cnt_q);
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                fill_q   <= fill_q + 1'b1;
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q   <= S_RUN;
                        cnt_q     <= '0;
                        missed_q  <= 1'b0;
                        inj_cnt_q <= '0;
                    end
                end
                S_RUN: begin
                    cnt_q <= sat_inc32(cnt_q);
                    if (pop) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        fill_q   <= fill_rem;
                    end
                    if (hit)  inj_cnt_q <= sat_inc8(inj_cnt_q);
                    if (late) missed_q  <= 1'b1;
                    if (fill_rem == '0) state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_verinject_ff_scheduler.sv
// Bench for verinject_ff_scheduler: directed scenarios plus randomized runs, all
// checked every cycle against a queue-based reference model of the scheduling rules.
module tb_verinject_ff_scheduler;

    localparam int          DEPTH = 4;
    localparam logic [31:0] IDLE  = 32'hFFFFFFFF;

    logic        clock = 1'b0;
    logic        reset_n, cfg_valid, cfg_ready, start, abort;
    logic [31:0] cfg_cycle, cfg_target, bus;
    logic        busy, done, missed;
    logic [7:0]  injected_count;

    verinject_ff_scheduler #(.DEPTH(DEPTH), .IDLE_STATE(IDLE)) dut (
        .clock(clock), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_cycle(cfg_cycle), .cfg_target(cfg_target), .start(start), .abort(abort),
        .verinject__injector_state(bus), .busy(busy), .done(done), .missed(missed),
        .injected_count(injected_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] cyc;
        logic [31:0] tgt;
    } ent_t;

    // Reference model: pending entries, whether a run is active or finished, run counter.
    ent_t   mq[$];
    bit     m_run, m_done, m_missed;
    longint m_cnt;
    int     m_inj;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        bit          hit;
        logic [31:0] exp_bus;
        hit     = m_run && (mq.size() > 0) && (longint'(mq[0].cyc) == m_cnt);
        exp_bus = hit ? mq[0].tgt : IDLE;
        if (chk_en) begin
            chk("bus",    bus,                    exp_bus);
            chk("busy",   32'(busy),              32'(m_run));
            chk("done",   32'(done),              32'(m_done));
            chk("missed", 32'(missed),            32'(m_missed));
            chk("injcnt", 32'(injected_count),    32'(m_inj));
            chk("ready",  32'(cfg_ready),         32'((mq.size() < DEPTH) && !m_run));
        end
        @(posedge clock);
        if (!reset_n) begin
            mq.delete();
            m_run = 0; m_done = 0; m_missed = 0; m_cnt = 0; m_inj = 0;
        end else if (abort) begin
            if (hit && m_inj < 255) m_inj++;
            mq.delete();
            m_run = 0; m_done = 0;
        end else if (m_run) begin
            if (mq.size() > 0) begin
                if (hit) begin
                    void'(mq.pop_front());
                    if (m_inj < 255) m_inj++;
                end else if (longint'(mq[0].cyc) < m_cnt) begin
                    void'(mq.pop_front());
                    m_missed = 1;
                end
            end
            if (mq.size() == 0) begin
                m_run = 0; m_done = 1;
            end
            if (m_cnt < 64'hFFFFFFFF) m_cnt++;
        end else begin
            if (cfg_valid && mq.size() < DEPTH) mq.push_back('{cyc: cfg_cycle, tgt: cfg_target});
            if (start) begin
                m_run = 1; m_done = 0; m_cnt = 0; m_missed = 0; m_inj = 0;
            end
        end
        #1;
    endtask

    task automatic load(input logic [31:0] c, input logic [31:0] t);
        cfg_valid = 1; cfg_cycle = c; cfg_target = t;
        tick();
        cfg_valid = 0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        tick();
        reset_n = 1;
    endtask

    task automatic go();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic run_to_done(input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        chk("run_reaches_done", 32'(done), 32'd1);
    endtask

    initial begin
        reset_n = 0; cfg_valid = 0; cfg_cycle = 0; cfg_target = 0; start = 0; abort = 0;
        @(negedge clock);
        tick();
        tick();
        reset_n = 1;
        chk_en = 1;
        chk("rst_bus",   bus,               IDLE);
        chk("rst_ready", 32'(cfg_ready),    32'd1);
        chk("rst_busy",  32'(busy),         32'd0);
        chk("rst_done",  32'(done),         32'd0);

        // Two scheduled injections at cycles 5 and 9.
        load(5, 17);
        load(9, 3);
        go();
        run_to_done(30);
        chk("basic_inj",    32'(injected_count), 32'd2);
        chk("basic_missed", 32'(missed),         32'd0);

        // Fill the FIFO, offer one more, verify back-pressure and count of injections.
        for (int i = 0; i < DEPTH; i++) load(32'(2 * i + 1), 32'(100 + i));
        chk("full_ready", 32'(cfg_ready), 32'd0);
        load(20, 999);
        go();
        chk("run_ready", 32'(cfg_ready), 32'd0);
        run_to_done(40);
        chk("full_inj", 32'(injected_count), 32'(DEPTH));

        // Equal cycles and a late entry.
        load(4, 1);
        load(4, 2);
        load(2, 7);
        go();
        run_to_done(30);
        chk("dup_missed", 32'(missed),         32'd1);
        chk("dup_inj",    32'(injected_count), 32'd1);

        // Abort at cnt=3 with an entry for cycle 10; a later run must find the FIFO empty.
        load(10, 5);
        go();
        repeat (3) tick();
        abort = 1;
        tick();
        abort = 0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        go();
        tick();
        chk("abort_flushed", 32'(done), 32'd1);
        chk("abort_inj",     32'(injected_count), 32'd0);

        // Start and abort together in IDLE.
        abort = 1;
        tick();
        abort = 0;
        load(3, 3);
        start = 1; abort = 1;
        tick();
        start = 0; abort = 0;
        chk("sa_busy", 32'(busy), 32'd0);
        go();
        tick();
        chk("sa_flushed", 32'(done), 32'd1);

        // Reset mid-run while an entry is being driven.
        load(4, 9);
        go();
        repeat (4) tick();
        chk("pre_reset_bus", bus, 32'd9);
        do_reset();
        chk("post_reset_bus",   bus,                 IDLE);
        chk("post_reset_busy",  32'(busy),           32'd0);
        chk("post_reset_ready", 32'(cfg_ready),      32'd1);
        chk("post_reset_inj",   32'(injected_count), 32'd0);

        // Randomized runs with occasional abort, reset and input noise.
        for (int t = 0; t < 60; t++) begin
            int n;
            n = $urandom_range(0, DEPTH + 1);
            for (int k = 0; k < n; k++) load($urandom_range(0, 12), $urandom);
            go();
            for (int c = 0; c < 40 && m_run; c++) begin
                cfg_valid  = ($urandom_range(0, 3) == 0);
                cfg_cycle  = $urandom_range(0, 12);
                cfg_target = $urandom;
                start      = ($urandom_range(0, 3) == 0);
                abort      = ($urandom_range(0, 40) == 0);
                reset_n    = ($urandom_range(0, 60) != 0);
                tick();
                cfg_valid = 0; start = 0; abort = 0; reset_n = 1;
            end
            if ($urandom_range(0, 4) == 0) begin
                abort = 1;
                tick();
                abort = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/verinject_ff_scheduler.md
VERINJECT_FF_SCHEDULER -- requirements
Module: verinject_ff_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued injection entries (power of two, 2..16).
REQ-002 SHALL have parameter IDLE_STATE, default 32'hFFFFFFFF, value driven on the injector-state bus when no injection is active.
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous active-low reset.
REQ-005 SHALL have port cfg_valid  input  1  entry offered.
REQ-006 SHALL have port cfg_ready  output  1  entry accepted when cfg_valid && cfg_ready at a rising edge.
REQ-007 SHALL have port cfg_cycle  input  32  run-cycle number at which to inject.
REQ-008 SHALL have port cfg_target  input  32  injector-state value (global bit index) to drive.
REQ-009 SHALL have port start  input  1  begin a run.
REQ-010 SHALL have port abort  input  1  end the run and flush the queue.
REQ-011 SHALL have port verinject__injector_state  output  32  state bus to all ff injectors.
REQ-012 SHALL have port busy  output  1  high in RUN.
REQ-013 SHALL have port done  output  1  high in DONE.
REQ-014 SHALL have port missed  output  1  sticky: an entry was discarded unexecuted.
REQ-015 SHALL have port injected_count  output  8  injections performed this run, saturating at 255.

Function
REQ-016 SHALL implement states IDLE, RUN, DONE, encoded in a registered state variable.
REQ-017 SHALL hold entries in a DEPTH-deep FIFO of {cycle, target} pairs, in acceptance order.
REQ-018 SHALL drive cfg_ready = FIFO not full && state != RUN.
REQ-019 SHALL, at an edge with start=1, abort=0, in IDLE or DONE: go to RUN, clear run counter cnt to 0, clear missed and injected_count.
REQ-020 SHALL ignore start while in RUN.
REQ-021 SHALL increment cnt by 1 per cycle in RUN, saturating at 32'hFFFFFFFF.
REQ-022 SHALL drive verinject__injector_state = head.target combinationally from registers when state==RUN, FIFO non-empty, and head.cycle == cnt; otherwise IDLE_STATE.
REQ-023 SHALL, at the edge ending a matching cycle (REQ-022), pop the head and increment injected_count; the target is visible for exactly one cycle.
REQ-024 SHALL, in RUN with head.cycle < cnt, pop the head without driving it and set missed; one such discard per cycle.
REQ-025 SHALL go from RUN to DONE at the first edge at which the FIFO is empty (including after the final pop).
REQ-026 SHALL keep entries with equal cycle values in order: the first injects, each later one is discarded per REQ-024.
REQ-027 SHALL, on abort=1 at an edge in any state, flush the FIFO and go to IDLE; abort has priority over start and cfg acceptance; an injection visible in that cycle is still counted.
REQ-028 SHALL, in DONE, hold missed, injected_count and cnt until the next start or abort.
REQ-029 SHALL treat start in IDLE with an empty FIFO as a run that enters DONE at the following edge with injected_count=0.

Reset
REQ-030 SHALL, at an edge with reset_n=0, regardless of other inputs: state IDLE, FIFO empty, cnt=0, missed=0, injected_count=0.
REQ-031 SHALL, during and after reset, drive verinject__injector_state = IDLE_STATE, busy=0, done=0, cfg_ready=1.
REQ-032 SHALL abandon a run in progress when reset asserts mid-RUN, with no further injection output.

Verification
REQ-033 SHALL test: load {5,17},{9,3}; start -> state bus =17 only in the cycle with cnt=5, =3 only at cnt=9, IDLE_STATE elsewhere; DONE after the pop at cnt=9; injected_count=2; missed=0.
REQ-034 SHALL test: load DEPTH entries -> cfg_ready=0 with FIFO full; extra cfg_valid is not accepted; cfg_ready=0 throughout RUN.
REQ-035 SHALL test: load {4,1},{4,2},{2,7} -> 1 injected at cnt=4, entry 2 discarded, entry 7 discarded; missed=1; injected_count=1.
REQ-036 SHALL test: abort at cnt=3 with {10,5} queued -> IDLE next cycle, FIFO empty, bus never shows 5.
REQ-037 SHALL test: start and abort asserted together in IDLE -> remains IDLE with FIFO flushed.
REQ-038 SHALL test: reset_n low mid-RUN with an entry matching that cycle -> bus IDLE_STATE from the next cycle, all outputs at reset values.
